// File: rtl/core_store.sv
`default_nettype none
// ============================================================================
// Module   : core_store
// Purpose  : Store alignment and bus-write sequencer. Shifts a store's data
//            into byte lanes, builds strobes, and issues one or two
//            word-aligned bus writes under a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module core_store (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  access_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Captured request context
    logic        split_q;
    logic        illegal_q;
    logic [31:0] hi_wdata;
    logic [3:0]  hi_strb;

    // Request decode
    logic [3:0]  size_mask;
    logic [31:0] data_masked;
    logic        illegal_in;
    logic [1:0]  off;
    logic [7:0]  strb8;
    logic [63:0] data64;

    assign off = addr[1:0];

    // Size decode; bit 2 of access_type carries no meaning for stores
    always_comb begin
        size_mask   = 4'b0000;
        data_masked = 32'h0;
        illegal_in  = 1'b0;
        casez (access_type)
            3'b?00: begin
                size_mask   = 4'b0001;
                data_masked = {24'h0, wdata[7:0]};
            end
            3'b?01: begin
                size_mask   = 4'b0011;
                data_masked = {16'h0, wdata[15:0]};
            end
            3'b?10: begin
                size_mask   = 4'b1111;
                data_masked = wdata;
            end
            default: begin
                illegal_in  = 1'b1;
            end
        endcase
    end

    // Lane placement across a two-word window; the upper half feeds beat 1
    assign strb8  = {4'b0000, size_mask} << off;
    assign data64 = {32'h0, data_masked} << {off, 3'b000};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = illegal_in ? FIN : BEAT0;
                end
            end
            BEAT0: begin
                if (bus_ready) begin
                    state_next = split_q ? BEAT1 : FIN;
                end
            end
            BEAT1: begin
                if (bus_ready) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Beat registers: load beat 0 on accept, swap in beat 1 after first handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_q   <= 1'b0;
            illegal_q <= 1'b0;
            hi_wdata  <= 32'h0;
            hi_strb   <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_strb  <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        illegal_q <= illegal_in;
                        split_q   <= (|strb8[7:4]) & ~illegal_in;
                        if (!illegal_in) begin
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= data64[31:0];
                            bus_strb  <= strb8[3:0];
                            hi_wdata  <= data64[63:32];
                            hi_strb   <= strb8[7:4];
                        end
                    end
                end
                BEAT0: begin
                    if (bus_ready) begin
                        if (split_q) begin
                            bus_addr  <= bus_addr + 32'd4;
                            bus_wdata <= hi_wdata;
                            bus_strb  <= hi_strb;
                        end else begin
                            bus_addr  <= 32'h0;
                            bus_wdata <= 32'h0;
                            bus_strb  <= 4'h0;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ready) begin
                        bus_addr  <= 32'h0;
                        bus_wdata <= 32'h0;
                        bus_strb  <= 4'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and status outputs are pure state decodes
    assign req_ready = (state == IDLE);
    assign bus_valid = (state == BEAT0) || (state == BEAT1);
    assign done      = (state == FIN);
    assign err       = (state == FIN) && illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_core_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_store
// Purpose  : Scoreboard bench for core_store. Expected beats and completions
//            are queued when a store is driven and compared as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_store;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  access_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;

    beat_t beat_q[$];
    logic  err_q[$];

    int vectors;
    int miscompares;

    core_store dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .access_type(access_type),
        .addr       (addr),
        .wdata      (wdata),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_strb   (bus_strb),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte-by-byte reference placement of a store into one or two beats
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                         output int nbeats, output beat_t b0, output beat_t b1);
        int nbytes;
        int lane;
        nbytes = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
        b0.a = {a[31:2], 2'b00};
        b1.a = b0.a + 32'd4;
        b0.d = 32'h0; b0.s = 4'h0;
        b1.d = 32'h0; b1.s = 4'h0;
        for (int i = 0; i < nbytes; i++) begin
            lane = int'(a[1:0]) + i;
            if (lane < 4) begin
                b0.d[8*lane +: 8] = d[8*i +: 8];
                b0.s[lane] = 1'b1;
            end else begin
                b1.d[8*(lane-4) +: 8] = d[8*i +: 8];
                b1.s[lane-4] = 1'b1;
            end
        end
        nbeats = (b1.s != 4'h0) ? 2 : 1;
    endtask

    // Drive one store, hold bus_ready low for the first 'stalls' beat cycles,
    // and check every beat and the completion against the scoreboard
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] t, input int stalls);
        int    nbeats;
        int    exp_lat;
        int    n;
        bit    seen;
        beat_t b0, b1;
        bit    ill;
        ill = (t[1:0] == 2'b11);
        if (!ill) begin
            model(a, d, t, nbeats, b0, b1);
            beat_q.push_back(b0);
            if (nbeats == 2) beat_q.push_back(b1);
            exp_lat = 1 + nbeats + stalls;
        end else begin
            exp_lat = 1;
        end
        err_q.push_back(ill);

        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        addr        = a;
        wdata       = d;
        access_type = t;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 40) begin
            bus_ready = (n > stalls);
            if (bus_valid) begin
                chk("strb_nonzero", {31'h0, (bus_strb != 4'h0)}, 32'd1);
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    chk("bus_addr", bus_addr, beat_q[0].a);
                    chk("bus_wdata", bus_wdata, beat_q[0].d);
                    chk("bus_strb", {28'h0, bus_strb}, {28'h0, beat_q[0].s});
                    if (bus_ready) void'(beat_q.pop_front());
                end
            end
            if (done) begin
                seen = 1'b1;
                chk("done_latency", n, exp_lat);
                chk("bus_valid_at_done", {31'h0, bus_valid}, 32'd0);
                if (err_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("err", {31'h0, err}, {31'h0, err_q.pop_front()});
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        bus_ready = 1'b1;
        chk("done_one_cycle", {31'h0, done}, 32'd0);
        chk("req_ready_after", {31'h0, req_ready}, 32'd1);
        chk("beats_drained", beat_q.size(), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        access_type = 3'b000;
        addr        = 32'h0;
        wdata       = 32'h0;
        bus_ready   = 1'b1;

        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_bus_valid", {31'h0, bus_valid}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_strb", {28'h0, bus_strb}, 32'h0);
        chk("rst_done_err", {30'h0, done, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_store(32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0);
        do_store(32'h0000_2003, 32'h1234_5678, 3'b001, 0);
        do_store(32'h0000_3002, 32'hCAFE_F00D, 3'b010, 3);
        do_store(32'hFFFF_FFFE, 32'h1122_3344, 3'b010, 0);
        do_store(32'h0000_4000, 32'hDEAD_BEEF, 3'b010, 0);
        do_store(32'h0000_5001, 32'h0000_ABCD, 3'b101, 1);
        do_store(32'h0000_6001, 32'h1234_5678, 3'b011, 0);
        do_store(32'h0000_7000, 32'h8765_4321, 3'b111, 2);

        // Reset while a beat is stalled
        @(negedge clk);
        req_valid   = 1'b1;
        addr        = 32'h0000_8001;
        wdata       = 32'h0102_0304;
        access_type = 3'b010;
        bus_ready   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_bus_valid", {31'h0, bus_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bus_valid", {31'h0, bus_valid}, 32'd0);
        chk("async_rst_req_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_no_done", {31'h0, done}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        bus_ready = 1'b1;
        do_store(32'h0000_9002, 32'h0000_55AA, 3'b001, 0);

        // Randomised stores
        for (int k = 0; k < 24; k++) begin
            logic [31:0] ra;
            logic [31:0] rd;
            logic [2:0]  rt;
            ra = $urandom;
            rd = $urandom;
            rt = 3'($urandom_range(0, 7));
            do_store(ra, rd, rt, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
